// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes, burst-master FSM states and beat geometry.
package axi_pkg;

  localparam int AXI_BEAT_BYTES = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R
  } axi_mst_state_e;

endpackage

// File: rtl/axi_intf.sv
// AXI4 bundle (INCR bursts, single ID) shared by the burst master and the RAM responder.
interface AXI_Intf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);

  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic              arvalid;
  logic              arready;

  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport AXI_M (
    output awaddr, awlen, awvalid, input awready,
    output wdata, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arlen, arvalid, input arready,
    input  rdata, rresp, rlast, rvalid, output rready
  );

  modport AXI_S (
    input  awaddr, awlen, awvalid, output awready,
    input  wdata, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arlen, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst initiator: local command -> AW/W/B write or AR/R read burst,
// with write data and read data carried on combinational valid/ready pass-through streams.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic [1:0]        done_resp,
  output logic              busy,
  AXI_Intf.AXI_M            axi
);

  localparam int CNT_W = LEN_W + 1;

  axi_mst_state_e    state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  beat_q;
  logic              err_seen_q;
  axi_resp_e         err_resp_q;
  logic              done_q;
  axi_resp_e         done_resp_q;
  axi_resp_e         r_resp;

  logic cmd_fire, w_fire, b_fire, r_fire, last_w;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign w_fire   = (state_q == S_W) && wr_valid && axi.wready;
  assign b_fire   = (state_q == S_B) && axi.bvalid;
  assign r_fire   = (state_q == S_R) && axi.rvalid && rd_ready;
  assign last_w   = (beat_q == {1'b0, len_q});

  assign axi.awaddr = addr_q;
  assign axi.awlen  = len_q;
  assign axi.araddr = addr_q;
  assign axi.arlen  = len_q;

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign done_resp = done_resp_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no path infers a latch.
    state_d     = state_q;
    cmd_ready   = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.wdata   = '0;
    axi.wlast   = 1'b0;
    wr_ready    = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    rd_valid    = 1'b0;
    rd_data     = '0;
    rd_last     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = aresetn;
        if (cmd_valid && aresetn) state_d = cmd_write ? S_AW : S_AR;
      end
      S_AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) state_d = S_W;
      end
      S_W: begin
        axi.wvalid = wr_valid;
        axi.wdata  = wr_data;
        axi.wlast  = last_w;
        wr_ready   = axi.wready;
        if (w_fire && last_w) state_d = S_B;
      end
      S_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_d = S_IDLE;
      end
      S_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_d = S_R;
      end
      S_R: begin
        rd_valid   = axi.rvalid;
        rd_data    = axi.rdata;
        rd_last    = axi.rlast;
        axi.rready = rd_ready;
        if (r_fire && axi.rlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Completion response of a read: first error wins, then a beat-count mismatch.
  always_comb begin
    r_resp = OKAY;
    if (err_seen_q)                    r_resp = err_resp_q;
    else if (axi.rresp != OKAY)        r_resp = axi_resp_e'(axi.rresp);
    else if (beat_q != {1'b0, len_q})  r_resp = SLVERR;
  end

  always_ff @(posedge aclk) begin
    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    if (!aresetn) begin
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      err_seen_q  <= 1'b0;
      err_resp_q  <= OKAY;
      done_q      <= 1'b0;
      done_resp_q <= OKAY;
    end else begin
      done_q      <= 1'b0;
      done_resp_q <= OKAY;
      if (cmd_fire) begin
        addr_q     <= cmd_addr & ~ADDR_W'(AXI_BEAT_BYTES - 1);
        len_q      <= cmd_len;
        beat_q     <= '0;
        err_seen_q <= 1'b0;
        err_resp_q <= OKAY;
      end
      // Saturate so a runaway read (missing RLAST) still reports a count mismatch.
      if ((w_fire || r_fire) && (beat_q != '1)) beat_q <= beat_q + CNT_W'(1);
      if (r_fire && (axi.rresp != OKAY) && !err_seen_q) begin
        err_seen_q <= 1'b1;
        err_resp_q <= axi_resp_e'(axi.rresp);
      end
      if (b_fire) begin
        done_q      <= 1'b1;
        done_resp_q <= axi_resp_e'(axi.bresp);
      end
      if (r_fire && axi.rlast) begin
        done_q      <= 1'b1;
        done_resp_q <= r_resp;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with a small behavioural AXI RAM responder.
module tb_axi_burst_master;

  logic        aclk;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        rd_valid;
  logic        rd_ready;
  logic        done;
  logic [1:0]  done_resp;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  AXI_Intf #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) axi ();

  axi_burst_master #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .done      (done),
    .done_resp (done_resp),
    .busy      (busy),
    .axi       (axi.AXI_M)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Responder: always address/data ready, B one cycle after the last W beat,
  // R streamed back-to-back with knobs for early/late RLAST and error responses.
  logic [31:0] mem [0:255];
  logic [9:0]  waddr, raddr;
  logic [8:0]  rbeat;
  logic [7:0]  rlen;
  int          early_last  = -1;
  int          extra_beats = 0;
  int          err_beat    = -1;
  logic [1:0]  err_code    = 2'b00;
  int          err_beat2   = -1;
  logic [1:0]  err_code2   = 2'b00;
  logic [1:0]  b_code      = 2'b00;

  assign axi.awready = 1'b1;
  assign axi.wready  = 1'b1;
  assign axi.arready = 1'b1;
  assign axi.rdata   = mem[raddr[9:2]];
  assign axi.rlast   = axi.rvalid && ((int'(rbeat) == early_last) ||
                                      (int'(rbeat) == int'(rlen) + extra_beats));
  assign axi.rresp   = (int'(rbeat) == err_beat)  ? err_code  :
                       (int'(rbeat) == err_beat2) ? err_code2 : 2'b00;

  always @(posedge aclk) begin
    if (!aresetn) begin
      axi.bvalid <= 1'b0;
      axi.bresp  <= 2'b00;
      axi.rvalid <= 1'b0;
      waddr      <= '0;
      raddr      <= '0;
      rbeat      <= '0;
      rlen       <= '0;
    end else begin
      if (axi.awvalid && axi.awready) waddr <= axi.awaddr[9:0];
      if (axi.wvalid && axi.wready) begin
        mem[waddr[9:2]] <= axi.wdata;
        waddr           <= waddr + 10'd4;
        if (axi.wlast) begin
          axi.bvalid <= 1'b1;
          axi.bresp  <= b_code;
        end
      end
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        raddr      <= axi.araddr[9:0];
        rlen       <= axi.arlen;
        rbeat      <= '0;
        axi.rvalid <= 1'b1;
      end else if (axi.rvalid && axi.rready) begin
        raddr <= raddr + 10'd4;
        rbeat <= rbeat + 9'd1;
        if (axi.rlast) axi.rvalid <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Read burst with rd_ready held high; counts beats up to the RLAST handshake.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input string tag,
                         input int exp_beats, input logic [1:0] exp_resp);
    int beats;
    bit seen_last;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
    #1;
    check({tag, "_accept"}, {63'd0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0;
    rd_ready  = 1'b1;
    beats     = 0;
    seen_last = 1'b0;
    for (int c = 0; c < 600 && !seen_last; c++) begin
      #1;
      if (rd_valid && rd_ready) begin
        beats++;
        seen_last = rd_last;
      end
      tick();
    end
    rd_ready = 1'b0;
    check({tag, "_beats"}, 64'(beats), 64'(exp_beats));
    check({tag, "_done"}, {61'd0, done, done_resp}, {61'd0, 1'b1, exp_resp});
  endtask

  initial begin
    int          k;
    logic [31:0] ed;

    aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_axi_ctrl", {58'd0, axi.awvalid, axi.wvalid, axi.wlast, axi.bready,
                           axi.arvalid, axi.rready}, 64'd0);
    check("rst_local", {56'd0, wr_ready, rd_valid, rd_last, done, done_resp, busy, cmd_ready}, 64'd0);
    check("rst_aw", {24'd0, axi.awaddr, axi.awlen}, 64'd0);
    check("rst_ar", {24'd0, axi.araddr, axi.arlen}, 64'd0);
    check("rst_wdata", {32'd0, axi.wdata}, 64'd0);
    aresetn = 1'b1;
    tick();
    check("idle_ready", {62'd0, cmd_ready, busy}, 64'b10);

    // Write 4 beats at 0x10, data A0..A3
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_len = 8'd3;
    #1;
    check("wr1_accept", {63'd0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 32'hA0;
    #1;
    check("wr1_aw", {23'd0, axi.awvalid, axi.awaddr, axi.awlen}, {23'd0, 1'b1, 32'h10, 8'd3});
    check("wr1_no_w_in_aw", {61'd0, axi.wvalid, wr_ready, busy}, 64'b001);
    tick();
    for (int i = 0; i < 4; i++) begin
      ed = 32'hA0 + 32'(i);
      wr_data = ed;
      #1;
      check("wr1_beat", {29'd0, axi.wvalid, axi.wdata, axi.wlast, wr_ready, axi.awvalid},
            {29'd0, 1'b1, ed, (i == 3), 1'b1, 1'b0});
      tick();
    end
    wr_valid = 1'b0;
    #1;
    check("wr1_b", {61'd0, axi.bready, axi.wvalid, done}, 64'b100);
    tick();
    check("wr1_done", {61'd0, done, done_resp}, 64'b100);
    tick();
    check("wr1_done_pulse", {62'd0, done, busy}, 64'd0);

    // Read back with rd_ready toggling 1,0,1,0
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_len = 8'd3;
    tick();
    cmd_valid = 1'b0;
    #1;
    check("rd1_ar", {23'd0, axi.arvalid, axi.araddr, axi.arlen}, {23'd0, 1'b1, 32'h10, 8'd3});
    tick();
    k = 0;
    for (int c = 0; c < 16 && k < 4; c++) begin
      rd_ready = (c % 2 == 0);
      #1;
      check("rd1_rready", {63'd0, axi.rready}, {63'd0, rd_ready});
      if (rd_valid && rd_ready) begin
        ed = 32'hA0 + 32'(k);
        check("rd1_beat", {31'd0, rd_data, rd_last}, {31'd0, ed, (k == 3)});
        k++;
      end
      tick();
    end
    rd_ready = 1'b0;
    check("rd1_beats", 64'(k), 64'd4);
    check("rd1_done", {61'd0, done, done_resp}, 64'b100);

    // Stalled write stream, BRESP DECERR reported through done_resp
    b_code = 2'b11;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_len = 8'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = 32'hB0 + 32'(i);
      #1;
      check("stall_pre", {62'd0, axi.wvalid, axi.wlast}, 64'b10);
      tick();
    end
    wr_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_hold", {61'd0, axi.wvalid, axi.wlast, busy}, 64'b001);
      tick();
    end
    for (int i = 2; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = 32'hB0 + 32'(i);
      #1;
      check("stall_post", {62'd0, axi.wvalid, axi.wlast}, {62'd0, 1'b1, (i == 3)});
      tick();
    end
    wr_valid = 1'b0;
    tick();
    check("stall_done", {61'd0, done, done_resp}, 64'b111);
    check("stall_mem_lo", {mem[16], mem[17]}, {32'hB0, 32'hB1});
    check("stall_mem_hi", {mem[18], mem[19]}, {32'hB2, 32'hB3});
    b_code = 2'b00;

    // Early RLAST on beat 2 of 4
    early_last = 1;
    do_read(32'h10, 8'd3, "early_rlast", 2, 2'b10);
    early_last = -1;

    // RLAST after more than len+1 beats
    extra_beats = 2;
    do_read(32'h10, 8'd1, "late_rlast", 4, 2'b10);
    extra_beats = 0;

    // First non-OKAY RRESP wins over later ones
    err_beat = 1; err_code = 2'b11; err_beat2 = 2; err_code2 = 2'b10;
    do_read(32'h10, 8'd3, "rresp_first", 4, 2'b11);
    err_beat = -1; err_beat2 = -1;

    // Longest burst: 256 beats must not wrap the counter
    do_read(32'h0, 8'd255, "len255", 256, 2'b00);

    // Reset in W after 2 of 4 beats
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80; cmd_len = 8'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = 32'hD0 + 32'(i);
      tick();
    end
    aresetn = 1'b0;
    tick();
    check("mid_rst_valids", {55'd0, axi.awvalid, axi.wvalid, axi.wlast, axi.bready,
                             axi.arvalid, axi.rready, wr_ready, busy, done}, 64'd0);
    tick();
    check("mid_rst_no_done", {62'd0, done, busy}, 64'd0);
    aresetn = 1'b1; wr_valid = 1'b0;

    // Minimum-latency write (len 0) right after reset: done at cycle 4
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_len = 8'd0;
    #1;
    check("b2b_wr_accept", {63'd0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 32'hC0;
    #1;
    check("b2b_wr_aw", {23'd0, axi.awvalid, axi.awaddr, axi.awlen}, {23'd0, 1'b1, 32'h20, 8'd0});
    tick();
    #1;
    check("b2b_wr_w", {30'd0, axi.wvalid, axi.wlast, axi.wdata}, {30'd0, 2'b11, 32'hC0});
    tick();
    wr_valid = 1'b0;
    #1;
    check("b2b_wr_b", {61'd0, axi.bready, busy, done}, 64'b110);
    tick();

    // Read (unaligned address) offered in the done cycle of the write
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h23; cmd_len = 8'd0;
    #1;
    check("b2b_done_accept", {61'd0, cmd_ready, done, done_resp}, 64'b1100);
    tick();
    cmd_valid = 1'b0;
    #1;
    check("b2b_rd_ar", {23'd0, axi.arvalid, axi.araddr, axi.arlen}, {23'd0, 1'b1, 32'h20, 8'd0});
    tick();
    rd_ready = 1'b1;
    #1;
    check("b2b_rd_r", {30'd0, rd_valid, rd_last, rd_data}, {30'd0, 2'b11, 32'hC0});
    tick();
    rd_ready = 1'b0;
    check("b2b_rd_done", {60'd0, done, done_resp, busy}, 64'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
